// File: rtl/cpu_pkg.sv
// Shared CPU-side constants: loader state encoding, frame sync byte and the
// instruction-RAM address width also used by the fetch path.
package cpu_pkg;

  localparam int unsigned ImemAddrW = 9;
  localparam logic [7:0]  SyncByte  = 8'hA5;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLen0 = 3'd1;
  localparam logic [2:0] StLen1 = 3'd2;
  localparam logic [2:0] StData = 3'd3;
  localparam logic [2:0] StCsum = 3'd4;
  localparam logic [2:0] StDone = 3'd5;
  localparam logic [2:0] StErr  = 3'd6;

endpackage

// File: rtl/timeout_counter.sv
// Idle-cycle counter: clear has priority, counts while enabled, and saturates
// with tc held high once LIMIT cycles have elapsed.
module timeout_counter #(
  parameter int unsigned LIMIT = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == CW'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !tc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/inst_loader.sv
// UART-fed program loader: parses SYNC/LEN/DATA/CSUM frames, writes little-endian
// words to instruction RAM and releases cpu_hold once a verified image is in.
module inst_loader
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W  = ImemAddrW,
  parameter logic [7:0]  SYNC    = SyncByte,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [16:0] Depth = 17'(2 ** ADDR_W);

  logic [2:0]        state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       rem_q, rem_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [23:0]       wbuf_q, wbuf_d;
  logic [7:0]        csum_q, csum_d;
  logic              rdy_q, we_q, we_d, hold_q, hold_d, done_q, done_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic        accept, in_frame, tmo_tc;
  logic [15:0] len_full;

  assign accept   = rx_valid && rdy_q;
  assign in_frame = (state_q == StLen0) || (state_q == StLen1) ||
                    (state_q == StData) || (state_q == StCsum);
  assign len_full = {rx_data, len_lo_q};

  timeout_counter #(
    .LIMIT(TIMEOUT)
  ) u_timeout (
    .clock (clock),
    .reset (reset),
    .clear (accept || !in_frame),
    .enable(in_frame),
    .tc    (tmo_tc)
  );

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    rem_d    = rem_q;
    waddr_d  = waddr_q;
    bidx_d   = bidx_q;
    wbuf_d   = wbuf_q;
    csum_d   = csum_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    err_d    = err_q;

    case (state_q)
      StIdle, StErr: begin
        if (accept && rx_data == SYNC) begin
          state_d = StLen0;
          err_d   = 1'b0;
          bidx_d  = 2'd0;
        end
      end
      StLen0: begin
        if (accept) begin
          len_lo_d = rx_data;
          csum_d   = rx_data;
          state_d  = StLen1;
        end
      end
      StLen1: begin
        if (accept) begin
          csum_d  = csum_q ^ rx_data;
          rem_d   = len_full;
          waddr_d = '0;
          bidx_d  = 2'd0;
          if (len_full == 16'd0) begin
            state_d = StCsum;
          end else if ({1'b0, len_full} > Depth) begin
            state_d = StErr;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          csum_d = csum_q ^ rx_data;
          bidx_d = bidx_q + 2'd1;
          case (bidx_q)
            2'd0: wbuf_d[7:0]   = rx_data;
            2'd1: wbuf_d[15:8]  = rx_data;
            2'd2: wbuf_d[23:16] = rx_data;
            default: begin
              we_d    = 1'b1;
              addr_d  = waddr_q;
              wdata_d = {rx_data, wbuf_q};
              waddr_d = waddr_q + ADDR_W'(1);
              rem_d   = rem_q - 16'd1;
              if (rem_q == 16'd1) begin
                state_d = StCsum;
              end
            end
          endcase
        end
      end
      StCsum: begin
        if (accept) begin
          state_d = (rx_data == csum_q) ? StDone : StErr;
        end
      end
      StDone: ;
      default: state_d = StIdle;
    endcase

    // A byte landing in the terminal-count cycle still counts as on time.
    if (in_frame && tmo_tc && !accept) begin
      state_d = StErr;
    end

    if (state_d == StErr) begin
      err_d = 1'b1;
    end
    done_d = (state_d == StDone);
    hold_d = (state_d != StDone);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      len_lo_q <= '0;
      rem_q    <= '0;
      waddr_q  <= '0;
      bidx_q   <= '0;
      wbuf_q   <= '0;
      csum_q   <= '0;
      rdy_q    <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      hold_q   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      rem_q    <= rem_d;
      waddr_q  <= waddr_d;
      bidx_q   <= bidx_d;
      wbuf_q   <= wbuf_d;
      csum_q   <= csum_d;
      rdy_q    <= 1'b1;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign rx_ready   = rdy_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = hold_q;
  assign load_done  = done_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed frames, a vector table and
// randomized frame sequences checked against a frame-level expectation model.
module tb_inst_loader;

  localparam int AW    = 9;
  localparam int TMO   = 64;
  localparam int Depth = 512;

  logic          clock, rst_n;
  logic [7:0]    rx_data;
  logic          rx_valid, rx_ready, imem_we, cpu_hold, load_done, load_err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  inst_loader #(
    .ADDR_W (AW),
    .SYNC   (8'hA5),
    .TIMEOUT(TMO)
  ) dut (
    .clock     (clock),
    .reset     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total  = 0;
  int passed = 0;

  int unsigned act_a[$], exp_a[$];
  logic [31:0] act_d[$], exp_d[$];
  logic [31:0] wbuf[1024];
  int          dup_cnt = 0;
  logic        prev_we = 1'b0;

  // Write monitor: every strobe cycle is one RAM write; back-to-back strobes are illegal.
  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      act_a.push_back(int'(imem_addr));
      act_d.push_back(imem_wdata);
      if (prev_we) dup_cnt <= dup_cnt + 1;
    end
    prev_we <= (imem_we === 1'b1);
  end

  typedef struct {
    int n;
    bit corrupt;
    bit exp_done;
    bit exp_err;
    int exp_writes;
  } vec_t;

  vec_t vt[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic idle(input int c);
    repeat (c) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic gap(input int maxgap);
    if (maxgap > 0) idle(int'($urandom_range(0, maxgap)));
  endtask

  // Sends one frame of n words from wbuf and records the writes it must cause.
  task automatic send_frame(input int n, input bit corrupt, input int maxgap);
    logic [7:0] cs, b;
    logic [15:0] len;
    len = 16'(n);
    cs  = len[7:0] ^ len[15:8];
    send_byte(8'hA5); gap(maxgap);
    send_byte(len[7:0]); gap(maxgap);
    send_byte(len[15:8]); gap(maxgap);
    if (n > Depth) return;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        b  = wbuf[i][8*k +: 8];
        cs = cs ^ b;
        send_byte(b); gap(maxgap);
      end
      exp_a.push_back(i);
      exp_d.push_back(wbuf[i]);
    end
    send_byte(corrupt ? (cs ^ 8'h5A) : cs);
  endtask

  task automatic compare_writes(input string name);
    int n;
    idle(2);
    check({name, " write count"}, 32'(act_a.size()), 32'(exp_a.size()));
    n = (act_a.size() < exp_a.size()) ? act_a.size() : exp_a.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s addr[%0d]", name, i), act_a[i], exp_a[i]);
      check($sformatf("%s data[%0d]", name, i), act_d[i], exp_d[i]);
    end
    act_a.delete(); act_d.delete(); exp_a.delete(); exp_d.delete();
  endtask

  task automatic check_status(input string name, input bit done, input bit err);
    idle(3);
    check({name, " load_done"}, 32'(load_done), 32'(done));
    check({name, " load_err"}, 32'(load_err), 32'(err));
    check({name, " cpu_hold"}, 32'(cpu_hold), 32'(!done));
  endtask

  task automatic check_reset_vals(input string name);
    check({name, " rx_ready"}, 32'(rx_ready), 32'd1);
    check({name, " imem_we"}, 32'(imem_we), 32'd0);
    check({name, " imem_addr"}, 32'(imem_addr), 32'd0);
    check({name, " imem_wdata"}, imem_wdata, 32'd0);
    check({name, " cpu_hold"}, 32'(cpu_hold), 32'd1);
    check({name, " load_done"}, 32'(load_done), 32'd0);
    check({name, " load_err"}, 32'(load_err), 32'd0);
  endtask

  // Asserts reset between clock edges and checks outputs before any edge arrives.
  task automatic async_reset_check(input string name);
    #2 rst_n = 1'b0;
    #1 check_reset_vals(name);
    #4 rst_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    #7 rst_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic send_list(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  initial begin
    logic [7:0] frame1[$];
    bit model_done, model_err;
    int n;
    bit corrupt;
    logic [7:0] g;

    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    #12 check_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clock);
    #1;

    // Two-word frame with hand-computed checksum 0x31.
    frame1 = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h20,
               8'h08, 8'h00, 8'h00, 8'h08, 8'h31};
    send_list(frame1);
    exp_a.push_back(0); exp_d.push_back(32'h2000_0013);
    exp_a.push_back(1); exp_d.push_back(32'h0800_0008);
    compare_writes("t1");
    check_status("t1", 1'b1, 1'b0);

    // Corrupted checksum, then a clean retry without reset.
    do_reset();
    frame1[11] = 8'h32;
    send_list(frame1);
    exp_a.push_back(0); exp_d.push_back(32'h2000_0013);
    exp_a.push_back(1); exp_d.push_back(32'h0800_0008);
    compare_writes("t2 bad");
    check_status("t2 bad", 1'b0, 1'b1);
    frame1[11] = 8'h31;
    send_list(frame1);
    exp_a.push_back(0); exp_d.push_back(32'h2000_0013);
    exp_a.push_back(1); exp_d.push_back(32'h0800_0008);
    compare_writes("t2 retry");
    check_status("t2 retry", 1'b1, 1'b0);

    // Garbage before SYNC, then a zero-length frame.
    do_reset();
    send_list('{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00});
    compare_writes("t3");
    check_status("t3", 1'b1, 1'b0);

    // Oversized length: error right after LEN_HI, trailing bytes write nothing.
    do_reset();
    send_list('{8'hA5, 8'h01, 8'h02});
    idle(1);
    check("t4 err after len", 32'(load_err), 32'd1);
    send_list('{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88});
    compare_writes("t4");
    check_status("t4", 1'b0, 1'b1);
    async_reset_check("t4 async reset");

    // Timeout after the second data byte, then SYNC starts a clean frame.
    do_reset();
    send_list('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22});
    idle(TMO + 5);
    check("t5 timeout err", 32'(load_err), 32'd1);
    check("t5 timeout hold", 32'(cpu_hold), 32'd1);
    compare_writes("t5 timeout");
    wbuf[0] = 32'hCAFE_F00D;
    send_frame(1, 1'b0, 0);
    compare_writes("t5 recover");
    check_status("t5 recover", 1'b1, 1'b0);

    // Stall well under the limit must not abort; checksum 0x45.
    do_reset();
    send_list('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22});
    idle(TMO - 10);
    send_list('{8'h33, 8'h44, 8'h45});
    exp_a.push_back(0); exp_d.push_back(32'h4433_2211);
    compare_writes("t5 short stall");
    check_status("t5 short stall", 1'b1, 1'b0);

    // Reset mid-frame after two words; loader restarts from IDLE.
    do_reset();
    send_list('{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                8'h55, 8'h66, 8'h77, 8'h88, 8'h99});
    exp_a.push_back(0); exp_d.push_back(32'h4433_2211);
    exp_a.push_back(1); exp_d.push_back(32'h8877_6655);
    async_reset_check("t5 mid-frame reset");
    compare_writes("t5 mid-frame");
    send_list('{8'hA5, 8'h00, 8'h00, 8'h00});
    compare_writes("t5 after reset");
    check_status("t5 after reset", 1'b1, 1'b0);

    // Full-depth frame, bytes every cycle.
    do_reset();
    for (int i = 0; i < Depth; i++) wbuf[i] = $urandom;
    send_frame(Depth, 1'b0, 0);
    idle(2);
    if (act_a.size() == Depth) check("t6 last addr", act_a[Depth-1], 32'h1FF);
    else check("t6 last addr present", 32'(act_a.size()), 32'(Depth));
    compare_writes("t6");
    check_status("t6", 1'b1, 1'b0);
    send_list('{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hA5});
    compare_writes("t6 after done");
    check_status("t6 after done", 1'b1, 1'b0);
    async_reset_check("t6 async reset");

    vt[0] = '{n: 2,   corrupt: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 2};
    vt[1] = '{n: 2,   corrupt: 1'b1, exp_done: 1'b0, exp_err: 1'b1, exp_writes: 2};
    vt[2] = '{n: 0,   corrupt: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 0};
    vt[3] = '{n: 0,   corrupt: 1'b1, exp_done: 1'b0, exp_err: 1'b1, exp_writes: 0};
    vt[4] = '{n: 513, corrupt: 1'b0, exp_done: 1'b0, exp_err: 1'b1, exp_writes: 0};
    vt[5] = '{n: 1,   corrupt: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 1};
    vt[6] = '{n: 7,   corrupt: 1'b1, exp_done: 1'b0, exp_err: 1'b1, exp_writes: 7};
    foreach (vt[v]) begin
      do_reset();
      for (int i = 0; i < 8; i++) wbuf[i] = (32'h0101_0101 * 32'(v + 1)) ^ 32'(i << 4);
      send_frame(vt[v].n, vt[v].corrupt, 2);
      idle(2);
      check($sformatf("vec%0d writes", v), 32'(act_a.size()), 32'(vt[v].exp_writes));
      compare_writes($sformatf("vec%0d", v));
      check_status($sformatf("vec%0d", v), vt[v].exp_done, vt[v].exp_err);
    end

    // Randomized frame sequences; DONE is sticky so each run ends at the first good frame.
    for (int r = 0; r < 10; r++) begin
      do_reset();
      model_done = 1'b0;
      model_err  = 1'b0;
      for (int f = 0; f < 3 && !model_done; f++) begin
        for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
          g = 8'($urandom_range(0, 255));
          if (g == 8'hA5) g = 8'h5B;
          send_byte(g);
        end
        n       = ($urandom_range(0, 7) == 0) ? 520 : int'($urandom_range(0, 6));
        corrupt = ($urandom_range(0, 2) == 0);
        for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
        send_frame(n, corrupt, 3);
        if (n > Depth || corrupt) begin
          model_err = 1'b1; model_done = 1'b0;
        end else begin
          model_err = 1'b0; model_done = 1'b1;
        end
        compare_writes($sformatf("rnd%0d.%0d", r, f));
        check_status($sformatf("rnd%0d.%0d", r, f), model_done, model_err);
      end
    end

    idle(2);
    check("single-cycle strobes", 32'(dup_cnt), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
